// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters, trained by resolved branches,
// raising a registered redirect whenever the carried prediction was wrong.
module branch_predict_unit #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] lookup_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag;
    logic [ENTRIES-1:0][31:0]       target;
    logic [ENTRIES-1:0][1:0]        ctr;
    logic [IDX_W-1:0]               l_idx, u_idx;
    logic [TAG_W-1:0]               l_tag, u_tag;
    logic                           l_hit, u_hit, mp, unused_bits;
    logic [1:0]                     u_ctr;

    assign {l_tag, l_idx} = lookup_pc[31:2];
    assign {u_tag, u_idx} = upd_pc[31:2];
    assign unused_bits    = ^lookup_pc[1:0];

    // Lookup reads pre-update state; no bypass from a same-cycle write.
    assign l_hit       = valid[l_idx] && tag[l_idx] == l_tag;
    assign pred_taken  = l_hit && ctr[l_idx][1];
    assign pred_target = l_hit ? target[l_idx] : '0;

    assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
    assign u_ctr = !u_hit ? 2'b10 :
                   upd_taken ? (ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1) :
                               (ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1);
    assign mp    = upd_valid && (upd_taken != upd_pred_taken ||
                                 (upd_taken && upd_target != upd_pred_target));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid          <= '0;
            tag            <= '0;
            target         <= '0;
            ctr            <= {ENTRIES{2'b01}};
            mispredict     <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            mispredict <= mp;
            if (mp) begin
                redirect_pc    <= upd_taken ? upd_target : upd_pc + 32'd8;
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
            if (flush)
                valid <= '0;
            else if (upd_valid && (u_hit || upd_taken)) begin
                valid[u_idx] <= 1'b1;
                tag[u_idx]   <= u_tag;
                ctr[u_idx]   <= u_ctr;
                if (upd_taken)
                    target[u_idx] <= upd_target;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plan plus randomized updates checked against a per-index table model.
module tb_branch_predict_unit;
    logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [31:0] upd_pred_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc, mispredict_cnt;

    int vectors = 0, miscompares = 0;

    // Model: each slot remembers the full word address of its resident branch.
    bit          mv   [16];
    int unsigned mline[16];
    logic [31:0] mtgt [16];
    int          mctr [16];
    logic [31:0] mcnt;

    logic [31:0] pool [8] = '{32'h0000_0040, 32'h0000_0440, 32'h0000_0080, 32'hBFC0_0010,
                              32'h1000_0044, 32'hBFC0_0050, 32'h0000_0C40, 32'h8000_0084};

    branch_predict_unit #(.ENTRIES(16)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit mhit(input logic [31:0] pc);
        int i = int'((pc / 4) % 16);
        return mv[i] && mline[i] == pc / 4;
    endfunction

    function automatic bit mpt(input logic [31:0] pc);
        return mhit(pc) && mctr[int'((pc / 4) % 16)] >= 2;
    endfunction

    function automatic logic [31:0] mptg(input logic [31:0] pc);
        return mhit(pc) ? mtgt[int'((pc / 4) % 16)] : 32'h0;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mline[i] = 0; mtgt[i] = '0; mctr[i] = 1;
        end
        mcnt = '0;
    endtask

    task automatic mupd(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        int i = int'((pc / 4) % 16);
        if (mhit(pc)) begin
            mctr[i] = t ? (mctr[i] < 3 ? mctr[i] + 1 : 3) : (mctr[i] > 0 ? mctr[i] - 1 : 0);
            if (t) mtgt[i] = tg;
        end else if (t) begin
            mv[i] = 1; mline[i] = pc / 4; mtgt[i] = tg; mctr[i] = 2;
        end
    endtask

    task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utg, input bit upt, input logic [31:0] uptg, input bit fl);
        bit          emp;
        logic [31:0] erp;
        @(negedge clk);
        lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        upd_pred_taken = upt; upd_pred_target = uptg; flush = fl;
        #1;
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, mpt(lpc)});
        chk("pred_target", pred_target, mptg(lpc));
        emp = uv && (ut != upt || (ut && utg != uptg));
        erp = ut ? utg : upc + 32'd8;
        if (emp) mcnt = mcnt + 32'd1;
        if (fl) for (int i = 0; i < 16; i++) mv[i] = 0;
        else if (uv) mupd(upc, ut, utg);
        @(posedge clk);
        #1;
        chk("mispredict", {31'b0, mispredict}, {31'b0, emp});
        if (emp) chk("redirect_pc", redirect_pc, erp);
        chk("mispredict_cnt", mispredict_cnt, mcnt);
        upd_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Resolved update carrying whatever the model would have predicted for that PC.
    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(pc, 1, pc, t, tg, mpt(pc), mptg(pc), 0);
    endtask

    initial begin
        mreset();
        repeat (2) @(negedge clk);
        lookup_pc = 32'hBFC0_0010;
        #1;
        chk("rst_mispredict", {31'b0, mispredict}, 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_cnt", mispredict_cnt, 32'h0);
        chk("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("rst_pred_target", pred_target, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Cold miss then train
        look(32'hBFC0_0010);
        step(32'hBFC0_0010, 1, 32'hBFC0_0010, 1, 32'hBFC0_0100, 0, 32'h0, 0);
        chk("train_redirect", redirect_pc, 32'hBFC0_0100);
        chk("train_cnt", mispredict_cnt, 32'h1);
        look(32'hBFC0_0010);
        // Counter hysteresis
        step(32'hBFC0_0010, 1, 32'hBFC0_0010, 0, 32'h0, 1, 32'hBFC0_0100, 0);
        chk("nt_redirect", redirect_pc, 32'hBFC0_0018);
        look(32'hBFC0_0010);
        repeat (2) upd(32'hBFC0_0010, 0, 32'h0);
        repeat (3) upd(32'hBFC0_0010, 1, 32'hBFC0_0100);
        look(32'hBFC0_0010);
        // Target change on hit
        step(32'h0, 1, 32'hBFC0_0010, 1, 32'hBFC0_0200, 1, 32'hBFC0_0100, 0);
        chk("retarget_redirect", redirect_pc, 32'hBFC0_0200);
        look(32'hBFC0_0010);
        // Alias eviction
        upd(32'h0000_0040, 1, 32'h1000);
        upd(32'h0000_0440, 1, 32'h2000);
        look(32'h0000_0440);
        look(32'h0000_0040);
        // Same-cycle collision, then flush with a taken update
        upd(32'h0000_0040, 1, 32'h3000);
        look(32'h0000_0040);
        step(32'h0000_0040, 1, 32'h0000_0080, 1, 32'h4000, 0, 32'h0, 1);
        look(32'h0000_0040);
        look(32'h0000_0080);
        look(32'hBFC0_0010);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] upc, tg;
            bit          carry;
            upc   = pool[$urandom_range(7)];
            tg    = ($urandom_range(3) == 0) ? $urandom : {16'h0, 4'($urandom_range(3)), 12'h0};
            carry = $urandom_range(1) == 1;
            step(pool[$urandom_range(7)], $urandom_range(9) < 7, upc, $urandom_range(1) == 1, tg,
                 carry ? mpt(upc) : $urandom_range(1) == 1, carry ? mptg(upc) : tg ^ 32'h1000,
                 $urandom_range(29) == 0);
        end

        // Counter wrap via forced count
        @(negedge clk);
        force dut.mispredict_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_cnt;
        mcnt = 32'hFFFF_FFFF;
        step(32'h0, 1, 32'h0000_0080, 1, 32'h5000, 0, 32'h0, 0);
        chk("wrap_cnt", mispredict_cnt, 32'h0);

        // Async reset while mispredict is high
        upd(32'h0000_0440, 1, 32'h6000);
        step(32'h0, 1, 32'h0000_0040, 0, 32'h0, 1, 32'h0, 0);
        #1;
        resetn = 1'b0;
        lookup_pc = 32'h0000_0440;
        #1;
        chk("arst_mispredict", {31'b0, mispredict}, 32'h0);
        chk("arst_redirect", redirect_pc, 32'h0);
        chk("arst_cnt", mispredict_cnt, 32'h0);
        chk("arst_pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("arst_pred_target", pred_target, 32'h0);
        mreset();
        @(negedge clk);
        resetn = 1'b1;
        look(32'h0000_0440);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
